// File: rtl/io_pkg.sv
// Shared definitions for the board I/O input stage: FSM encoding, datapath width, debounce default.
// Latency: n/a (package only). Backpressure: n/a.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        DONE         = 2'd3
    } in_state_t;

    localparam int DATA_W            = 32;
    localparam int DEFAULT_DB_CYCLES = 16;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for the confirm button; press is a one-cycle rising-edge pulse.
// Latency: raw edge to press is 2 + DB_CYCLES cycles for a clean input. Backpressure: none, free-running.
module input_debouncer
    import io_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic clock,
    input  logic rst,
    input  logic button_in,
    output logic db_level,
    output logic press
);

    localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

    logic [1:0]  sync;
    logic        btn_s;
    logic [15:0] db_cnt;
    logic        level_q;

    assign btn_s = sync[1];

    always_ff @(posedge clock) begin
        if (rst) begin
            sync     <= 2'b00;
            db_cnt   <= 16'd0;
            db_level <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            sync    <= {sync[0], button_in};
            level_q <= db_level;
            // Any sample agreeing with the current level restarts the stability window.
            if (btn_s == db_level) begin
                db_cnt <= 16'd0;
            end else if (db_cnt == CNT_LAST) begin
                db_level <= ~db_level;
                db_cnt   <= 16'd0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    assign press = db_level & ~level_q;

endmodule

// File: rtl/switch_input_handshake.sv
// Stalls the PC on an input instruction, waits for a clean button press and captures the switches (SWITCH_INPUT_SIGN_EXT_EN selects sign extension).
// Latency: press to in_valid 1 cycle. Backpressure: stall holds the PC while in_req is pending; withdrawing in_req aborts.
module switch_input_handshake
    import io_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int SW_WIDTH  = 16
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                button_in,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                in_req,
    output logic                stall,
    output logic                in_valid,
    output logic [DATA_W-1:0]   in_data,
    output logic                busy
);

    in_state_t             state;
    in_state_t             state_nxt;
    logic                  capture;
    logic [SW_WIDTH-1:0]   cap_reg;
    logic                  db_level;
    logic                  press;

    input_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .rst       (rst),
        .button_in (button_in),
        .db_level  (db_level),
        .press     (press)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // A button still held from the previous input must be released first.
                if (in_req) begin
                    state_nxt = db_level ? WAIT_RELEASE : WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (!in_req) begin
                    state_nxt = IDLE;
                end else if (!db_level) begin
                    state_nxt = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!in_req) begin
                    state_nxt = IDLE;
                end else if (press) begin
                    state_nxt = DONE;
                    capture   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= IDLE;
            cap_reg <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_reg <= switches;
            end
        end
    end

    assign stall    = in_req & (state != DONE) & ~rst;
    assign in_valid = (state == DONE) & in_req & ~rst;
    assign busy     = (state != IDLE) & ~rst;

`ifdef SWITCH_INPUT_SIGN_EXT_EN
    assign in_data = {{(DATA_W - SW_WIDTH){cap_reg[SW_WIDTH-1]}}, cap_reg};
`else
    assign in_data = {{(DATA_W - SW_WIDTH){1'b0}}, cap_reg};
`endif

endmodule

// File: tb/tb_switch_input_handshake.sv
// Directed plus randomized bench for switch_input_handshake, DB_CYCLES = 4, checked every cycle against a behavioural model.
module tb_switch_input_handshake;

    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        rst;
    logic        button_in;
    logic [15:0] switches;
    logic        in_req;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;
    bit last_valid;

    switch_input_handshake #(
        .DB_CYCLES (DB),
        .SW_WIDTH  (16)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .button_in (button_in),
        .switches  (switches),
        .in_req    (in_req),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Behavioural model: button history, debounced level, and the progress of the pending request.
    bit          m_s1, m_s2, m_level, m_prev;
    bit          hist[$];
    bit          m_active;     // a request is being served
    bit          m_need_rel;   // waiting for the held button to be let go
    bit          m_got;        // press captured, valid cycle now
    logic [31:0] m_data;

    function automatic logic [31:0] ext16(logic [15:0] v);
`ifdef SWITCH_INPUT_SIGN_EXT_EN
        return {{16{v[15]}}, v};
`else
        return {16'h0000, v};
`endif
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_prev = 0;
        hist.delete();
        m_active = 0; m_need_rel = 0; m_got = 0;
        m_data = 32'h0;
    endtask

    task automatic model_edge();
        bit lvl, prs, all_diff;
        if (rst) begin
            model_reset();
            return;
        end
        lvl = m_level;
        prs = m_level && !m_prev;
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        m_prev = m_level;
        all_diff = (hist.size() == DB);
        foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
        if (all_diff) begin
            m_level = !m_level;
            hist.delete();
        end
        m_s2 = m_s1;
        m_s1 = button_in;

        if (m_got) begin
            m_got = 0;
            m_active = 0;
        end else if (m_active && !in_req) begin
            m_active = 0;
        end else if (!m_active && in_req) begin
            m_active = 1;
            m_need_rel = lvl;
        end else if (m_active && m_need_rel) begin
            if (!lvl) m_need_rel = 0;
        end else if (m_active && prs) begin
            m_got = 1;
            m_data = ext16(switches);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        chk("stall",    32'(stall),    32'(in_req && !m_got && !rst));
        chk("in_valid", 32'(in_valid), 32'(m_got && in_req && !rst));
        chk("busy",     32'(busy),     32'(m_active && !rst));
        chk("in_data",  in_data,       m_data);
        last_valid = (in_valid === 1'b1);
        if (last_valid) nvalid++;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat;
        int btn_hold;

        rst = 1; button_in = 0; switches = 16'h0; in_req = 0;
        model_reset();
        @(posedge clock);
        #1;
        run(3);

        // Request with button low: stalled and busy, never valid.
        rst = 0; in_req = 1;
        nvalid = 0;
        run(10);
        chk("req_busy", 32'(busy), 32'h1);
        chk("req_no_valid", nvalid, 0);

        // Clean press: valid seen 2 + DB + 1 edges after the raw edge, i.e. tick 2 + DB + 2.
        switches = 16'h00A5; button_in = 1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (last_valid && lat < 0) lat = k;
        end
        chk("press_latency", lat, 2 + DB + 2);
        chk("a5_data", in_data, 32'h0000_00A5);
        in_req = 0; button_in = 0;
        run(10);

        // Top bit set on the switches.
        in_req = 1; switches = 16'h8001;
        run(2);
        button_in = 1;
        run(12);
        chk("ext_data", in_data, ext16(16'h8001));
        in_req = 0; button_in = 0;
        run(10);

        // Bounce 1-0-1-0 then stable: exactly one transfer.
        in_req = 1; switches = 16'h1234; nvalid = 0;
        run(2);
        button_in = 1; tick();
        button_in = 0; tick();
        button_in = 1; tick();
        button_in = 0; tick();
        button_in = 1;
        run(14);
        chk("bounce_count", nvalid, 1);
        chk("bounce_data", in_data, 32'h0000_1234);
        in_req = 0; button_in = 0;
        run(10);

        // Back-to-back requests with the button held through the first transfer.
        in_req = 1; switches = 16'h0F0F; nvalid = 0; button_in = 1;
        run(12);
        chk("b2b_first", nvalid, 1);
        run(6);
        chk("b2b_held", nvalid, 1);
        switches = 16'h3C3C; button_in = 0;
        run(8);
        button_in = 1;
        run(12);
        chk("b2b_second", nvalid, 2);
        chk("b2b_data", in_data, 32'h0000_3C3C);
        in_req = 0; button_in = 0;
        run(10);

        // Withdrawn request in WAIT_PRESS.
        in_req = 1; nvalid = 0;
        run(3);
        in_req = 0;
        run(2);
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_no_valid", nvalid, 0);

        // Reset in WAIT_PRESS clears capture.
        in_req = 1;
        run(3);
        rst = 1;
        run(2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", in_data, 32'h0);
        rst = 0; in_req = 0;
        run(4);

        // Randomized traffic.
        btn_hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (btn_hold == 0) begin
                button_in = 1'($urandom_range(0, 1));
                btn_hold = $urandom_range(1, 12);
            end
            btn_hold--;
            if ($urandom_range(0, 15) == 0) in_req = ~in_req;
            switches = 16'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 0;
        run(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_input_handshake.md
# switch_input_handshake

Upstream I/O stage feeding the single-cycle datapath's immediate/switch path. When the control unit decodes an input instruction, this block stalls the PC, debounces the confirm button, and captures the 16 board switches on a clean press. It then presents the value as a 32-bit word for exactly one cycle, in which the PC advances and the register file writes it. It replaces the ad-hoc debounce/one-shot pair at the top level with a single handshaked stage.

## Interface
- `DB_CYCLES`, default 16: consecutive stable synchronised samples required before the debounced level changes; legal range is 2 to 65535.
- `SW_WIDTH`, default 16: switch bus width; must be 16 or less.
- `clock`, in, 1: system clock, the divided processor clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `button_in`, in, 1: raw confirm button, asynchronous, active-high.
- `switches`, in, SW_WIDTH: raw switch bank.
- `in_req`, in, 1: input instruction currently decoded; held while the instruction is current.
- `stall`, out, 1: freezes the PC and blocks register-file writes; combinational.
- `in_valid`, out, 1: one-cycle pulse; `in_data` is valid and the write may occur.
- `in_data`, out, 32: captured switches extended to 32 bits.
- `busy`, out, 1: state is not IDLE; drives the "waiting for input" LED.

## Operation
- Synchroniser: `button_in` passes through 2 flops to produce `btn_s`.
- Debouncer:
  - 16-bit counter `db_cnt` clears whenever `btn_s` equals `db_level`, else increments.
  - When `db_cnt` equals DB_CYCLES-1 and `btn_s` still differs, `db_level` toggles and `db_cnt` clears.
  - `press` is a one-cycle pulse on a rising edge of `db_level`.
- FSM states: IDLE, WAIT_RELEASE, WAIT_PRESS, DONE.
  - IDLE: `in_req` with `db_level` high goes to WAIT_RELEASE, so a button still held from a previous input is not reused. `in_req` with `db_level` low goes to WAIT_PRESS.
  - WAIT_RELEASE: `db_level` low goes to WAIT_PRESS.
  - WAIT_PRESS: `press` goes to DONE; `switches` is sampled into `cap_reg` on the same edge.
  - DONE: goes to IDLE unconditionally.
  - Any non-IDLE state with `in_req` low goes to IDLE with no `in_valid` (instruction withdrawn). This takes priority over the transitions above, except in DONE.
- Outputs:
  - `stall` = `in_req` and (state is not DONE) and not `rst`.
  - `in_valid` = (state is DONE) and `in_req`.
  - `in_data` = `cap_reg` extended according to Configuration; it holds its value until the next capture.
- Back-to-back input instructions: DONE goes to IDLE. The next `in_req` sees the button still held and enters WAIT_RELEASE, so a second press is required.
- Switches changing while in WAIT_PRESS have no effect; only the value at the `press` edge is captured.

## Timing
- Reset values: state IDLE, sync flops 0, `db_level` 0, `db_cnt` 0, `cap_reg` 0.
  - During reset: `stall` 0, `in_valid` 0, `in_data` 0, `busy` 0.
- Raw button edge to `press`: 2 + DB_CYCLES cycles for a bounce-free input.
- `press` to `in_valid`: 1 cycle. `stall` drops in the same cycle `in_valid` rises.
- `in_req` rising to `stall` high: 0 cycles (combinational). The IDLE cycle itself is stalled.
- Reset mid-operation: returns to IDLE next edge and discards any partial capture. `cap_reg` also clears.

## Configuration
- `SWITCH_INPUT_SIGN_EXT_EN`:
  - Defined: `in_data` sign-extends `cap_reg` from bit SW_WIDTH-1, so switches can enter negative operands.
  - Undefined: `in_data` is zero-extended.

## Structure
- Shared package `io_pkg` holds:
  - the FSM state enum `in_state_t` (2 bits);
  - the `DATA_W = 32` constant;
  - the default `DB_CYCLES` constant.
- One sub-module, `input_debouncer`: contains the synchroniser, counter, `db_level` and `press`, parameterised by DB_CYCLES. The FSM and capture stay in the top block.

## Test plan
All scenarios use DB_CYCLES = 4.
- Reset, then `in_req`=1 with the button low: `stall`=1 and `busy`=1 from the next cycle; `in_valid` stays 0 indefinitely.
- Switches 0x00A5, clean press held 10 cycles: `press` arrives 6 cycles after the raw edge, `in_valid` 1 cycle later with `in_data`=0x000000A5, and `stall` drops in that cycle.
- Switches 0x8001 with `SWITCH_INPUT_SIGN_EXT_EN`: `in_data`=0xFFFF8001. Without the macro: 0x00008001.
- Button bouncing 1-0-1-0 at 1-cycle intervals, then stable high: only one `press` and one `in_valid`; no capture occurs during the bounce.
- Two consecutive `in_req` with the button held through the first `in_valid`: the second request sits in WAIT_RELEASE. `in_valid` occurs only after release plus a new press, capturing the new switch value.
- `in_req` dropped while in WAIT_PRESS, or `rst` asserted in WAIT_PRESS: state returns to IDLE next cycle with no `in_valid`. After `rst`, `in_data` reads 0.
